// File: rtl/alarm_sequencer.sv
// alarm_sequencer
//
// Alarm controller for the digital clock. Watches the running time from the
// clock/alarm register datapath and sequences one alarm event through
// ARMED -> RINGING -> (SNOOZE -> RINGING)* -> ARMED, with auto-stop after an
// unacknowledged ring and a blinking ring LED.
//
// Ports
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   tick_1s_i         one-cycle pulse per second from the clock counter
//   hour_i/min_i/sec_i current time, binary, stable except on the tick cycle
//   alarm_hour_i/alarm_min_i stored alarm time, binary
//   arm_i             level; 0 disarms from any state (highest priority)
//   snooze_pulse_i    one-cycle snooze request
//   stop_pulse_i      one-cycle stop request
//   ringing_o         high while RINGING
//   led_ring_o        blinking indicator while RINGING, 0 otherwise
//   snoozing_o        high while SNOOZE
//   snooze_count_o    snoozes used in the current event
//   missed_o          sticky: last event timed out unacknowledged
//   state_o           DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3
module alarm_sequencer #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3,
  parameter int BLINK_DIV      = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1s_i,
  input  logic [5:0] hour_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  input  logic [5:0] alarm_hour_i,
  input  logic [5:0] alarm_min_i,
  input  logic       arm_i,
  input  logic       snooze_pulse_i,
  input  logic       stop_pulse_i,
  output logic       ringing_o,
  output logic       led_ring_o,
  output logic       snoozing_o,
  output logic [1:0] snooze_count_o,
  output logic       missed_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_e;

  localparam int SNZ_TOTAL = SNOOZE_MIN * 60;
  localparam int RT_W      = $clog2(RING_TIMEOUT_S + 1);
  localparam int SR_W      = $clog2(SNZ_TOTAL + 1);
  localparam int BL_W      = $clog2(BLINK_DIV);

  // Timeout fires on the tick that would take ring_timer to RING_TIMEOUT_S,
  // so the compare is against the value just below it.
  localparam logic [RT_W-1:0] RT_PRE  = RT_W'(RING_TIMEOUT_S - 1);
  localparam logic [RT_W-1:0] RT_ONE  = RT_W'(1);
  localparam logic [SR_W-1:0] SR_LOAD = SR_W'(SNZ_TOTAL);
  localparam logic [SR_W-1:0] SR_ONE  = SR_W'(1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);
  localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
  localparam logic [1:0]      SC_MAX  = 2'(MAX_SNOOZE);

  state_e            state_q, state_d;
  logic [RT_W-1:0]   ring_timer_q, ring_timer_d;
  logic [SR_W-1:0]   snooze_rem_q, snooze_rem_d;
  logic [1:0]        snooze_cnt_q, snooze_cnt_d;
  logic              missed_q, missed_d;
  logic [BL_W-1:0]   blink_q, blink_d;
  logic              led_q, led_d;
  logic              ringing_q, snoozing_q;
  logic              fire;

  // Time compare happens only in the tick cycle; sec==0 coincides with exactly
  // one tick per minute, so the alarm can fire at most once per matching minute.
  assign fire = tick_1s_i && (hour_i == alarm_hour_i) && (min_i == alarm_min_i)
                && (sec_i == 6'd0);

  always_comb begin
    state_d      = state_q;
    ring_timer_d = ring_timer_q;
    snooze_rem_d = snooze_rem_q;
    snooze_cnt_d = snooze_cnt_q;
    missed_d     = missed_q;

    if (stop_pulse_i) begin
      missed_d = 1'b0;
    end

    if (!arm_i) begin
      state_d      = DISARMED;
      ring_timer_d = '0;
      snooze_rem_d = '0;
      snooze_cnt_d = '0;
      missed_d     = 1'b0;
    end else begin
      unique case (state_q)
        DISARMED: begin
          state_d = ARMED;
        end

        ARMED: begin
          if (fire) begin
            state_d      = RINGING;
            ring_timer_d = '0;
            missed_d     = 1'b0;
          end
        end

        RINGING: begin
          if (stop_pulse_i) begin
            state_d      = ARMED;
            snooze_cnt_d = '0;
          end else if (snooze_pulse_i && (snooze_cnt_q < SC_MAX)) begin
            state_d      = SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 2'd1;
            snooze_rem_d = SR_LOAD;
          end else if (tick_1s_i) begin
            if (ring_timer_q == RT_PRE) begin
              state_d      = ARMED;
              missed_d     = 1'b1;
              snooze_cnt_d = '0;
            end else begin
              ring_timer_d = ring_timer_q + RT_ONE;
            end
          end
        end

        SNOOZE: begin
          // Stop beats an expiry tick in the same cycle; snooze is ignored here.
          if (stop_pulse_i) begin
            state_d      = ARMED;
            snooze_cnt_d = '0;
          end else if (tick_1s_i) begin
            if (snooze_rem_q == SR_ONE) begin
              state_d      = RINGING;
              ring_timer_d = '0;
            end else begin
              snooze_rem_d = snooze_rem_q - SR_ONE;
            end
          end
        end

        default: begin
          state_d = DISARMED;
        end
      endcase
    end
  end

  // Blink generator: the LED starts lit on every RINGING entry and toggles
  // after each BLINK_DIV cycles spent in RINGING; it is dark everywhere else.
  always_comb begin
    blink_d = '0;
    led_d   = 1'b0;
    if (state_d == RINGING) begin
      if (state_q != RINGING) begin
        blink_d = '0;
        led_d   = 1'b1;
      end else if (blink_q == BL_LAST) begin
        blink_d = '0;
        led_d   = ~led_q;
      end else begin
        blink_d = blink_q + BL_ONE;
        led_d   = led_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DISARMED;
      ring_timer_q <= '0;
      snooze_rem_q <= '0;
      snooze_cnt_q <= '0;
      missed_q     <= 1'b0;
      blink_q      <= '0;
      led_q        <= 1'b0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_timer_q <= ring_timer_d;
      snooze_rem_q <= snooze_rem_d;
      snooze_cnt_q <= snooze_cnt_d;
      missed_q     <= missed_d;
      blink_q      <= blink_d;
      led_q        <= led_d;
      ringing_q    <= (state_d == RINGING);
      snoozing_q   <= (state_d == SNOOZE);
    end
  end

  assign ringing_o      = ringing_q;
  assign led_ring_o     = led_q;
  assign snoozing_o     = snoozing_q;
  assign snooze_count_o = snooze_cnt_q;
  assign missed_o       = missed_q;
  assign state_o        = state_q;

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Alarm controller for the digital clock. It compares the running clock time against the stored alarm time and sequences the alarm through arm, ring, snooze and timeout. It drives the ring indicator LED and status outputs. It sits beside the clock/alarm register datapath: it consumes that datapath's 1 s tick and time values, and replaces the direct hour/minute compare that currently drives the alarm LED.

## Interface
- SNOOZE_MIN, 5: snooze length in minutes (1..10).
- RING_TIMEOUT_S, 60: seconds of unacknowledged ringing before auto-stop (1..255).
- MAX_SNOOZE, 3: snoozes allowed per alarm event (0..3).
- BLINK_DIV, 50_000_000: clk cycles per half-period of led_ring blink (≥2).
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- tick_1s  in  1  one-cycle pulse per second from the clock counter.
- hour, min, sec  in  6 each  current clock time, binary; stable except on the tick cycle.
- alarm_hour, alarm_min  in  6 each  stored alarm time, binary.
- arm  in  1  level; 0 disarms from any state.
- snooze_pulse  in  1  one-cycle debounced, edge-detected request.
- stop_pulse  in  1  one-cycle debounced, edge-detected request.
- ringing  out  1  high while in RINGING.
- led_ring  out  1  blinking indicator while ringing.
- snoozing  out  1  high while in SNOOZE.
- snooze_count  out  2  snoozes used in the current event.
- missed  out  1  sticky: the last event timed out unacknowledged.
- state  out  2  DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3.

## Operation
- All outputs and internal counters are registered. On rst_n=0: state=DISARMED, all outputs 0, all counters 0.
- Any state with arm=0 → DISARMED on the next edge. Clears snooze_count, missed, and the timers. arm=0 has priority over every other input.
- DISARMED: arm=1 → ARMED.
- ARMED: fire condition is tick_1s=1 && hour==alarm_hour && min==alarm_min && sec==0, with inputs sampled in the tick cycle. On fire: → RINGING, ring_timer=0, missed=0. Fires at most once per matching minute, because sec==0 coincides with exactly one tick.
- RINGING, priority stop > snooze > timeout:
  - stop_pulse → ARMED, snooze_count=0.
  - snooze_pulse with snooze_count<MAX_SNOOZE → SNOOZE, snooze_count+1, snooze_rem=SNOOZE_MIN*60.
  - snooze_pulse with snooze_count==MAX_SNOOZE → ignored; stay RINGING.
  - On each tick_1s, ring_timer+1. When a tick makes ring_timer reach RING_TIMEOUT_S → ARMED, missed=1, snooze_count=0.
- SNOOZE:
  - On each tick_1s, snooze_rem−1. A tick with snooze_rem==1 → RINGING, ring_timer=0.
  - stop_pulse → ARMED, snooze_count=0; takes precedence over the expiry tick in the same cycle.
  - snooze_pulse is ignored.
- missed clears on stop_pulse in any state, or on arm=0.
- led_ring:
  - 1 on the first RINGING cycle; toggles every BLINK_DIV cycles while RINGING.
  - Forced 0 in all other states; the blink counter resets on RINGING entry.
- Widths:
  - ring_timer: clog2(RING_TIMEOUT_S+1) bits.
  - snooze_rem: clog2(SNOOZE_MIN*60+1) bits.
  - blink counter: clog2(BLINK_DIV) bits.
  - All counters saturate/wrap only as described above; no arithmetic on hour/min/sec.

## Timing
- Fire latency: ringing=1 on the edge after the matching tick cycle (1 cycle).
- stop/snooze latency: state and outputs update on the edge after the pulse cycle (1 cycle).
- Timeout: ringing drops 1 cycle after the RING_TIMEOUT_S-th tick counted in RINGING.
- Snooze expiry: ringing reasserts 1 cycle after the SNOOZE_MIN*60-th tick counted in SNOOZE.
- Reset mid-operation: asynchronous; outputs go to reset values immediately, without waiting for clk.
- A pulse arriving in the same cycle as tick_1s is acted on with the priority listed above; the tick's counter update is discarded if the state changes.
- alarm_hour/alarm_min changed while RINGING or SNOOZE: no effect on the current event; the new values apply to the next fire check in ARMED.

## Test plan
Bench parameters: SNOOZE_MIN=1, RING_TIMEOUT_S=5, MAX_SNOOZE=2, BLINK_DIV=4; tick_1s every 10 cycles.
- Fire: arm=1, alarm 07:30, time steps to 07:30:00 with tick → state=2, ringing=1 next cycle; led_ring reads 1,1,1,1,0,0,0,0 across 8 cycles.
- Stop: in RINGING, stop_pulse → state=1, ringing=0, snooze_count=0. No refire during 07:30:01–07:30:59.
- Snooze chain: snooze_pulse twice, each after re-ring; each snooze re-rings after exactly 60 ticks. A third snooze_pulse is ignored, state stays 2, snooze_count=2.
- Timeout: ring with no input → after 5 ticks state=1, missed=1. A subsequent stop_pulse clears missed.
- Simultaneous: stop_pulse and snooze_pulse in the same cycle → ARMED. In SNOOZE, stop_pulse coinciding with the expiry tick → ARMED, not RINGING.
- Disarm/reset: arm=0 during SNOOZE → state=0, all outputs 0 next cycle. rst_n=0 during RINGING clears outputs asynchronously; after release with arm=1 → ARMED.
